// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } muldiv_state_e;

    function automatic logic isSignedOp(input logic [1:0] opIn);
        return ~opIn[0];
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Combinational two's-complement negate, used for operand magnitudes and result fix-up.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    output logic [W-1:0] neg_o
);

    assign neg_o = (~val_i) + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, one bit per cycle, with the pipeline stall request.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = MULDIV_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] inRD1,
    input  logic [WIDTH-1:0] inRD2,
    input  logic             readHiLo,
    input  logic             flush,
    output logic [WIDTH-1:0] outHi,
    output logic [WIDTH-1:0] outLo,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic             stall
);

    localparam int CNT_W = $clog2(ITER);

    muldiv_state_e        state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     aMag_q, aMag_d;
    logic [WIDTH-1:0]     bMag_q, bMag_d;
    logic [WIDTH-1:0]     origA_q, origA_d;
    logic                 signA_q, signA_d;
    logic                 signB_q, signB_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 divZero_q, divZero_d;

    logic                 inSignA, inSignB;
    logic [WIDTH-1:0]     inNegA, inNegB, inMagA, inMagB;
    logic [WIDTH-1:0]     mulAddend;
    logic [WIDTH:0]       mulSum;
    logic [WIDTH+1:0]     divShift, divDiff;
    logic                 divGe;
    logic [2*WIDTH-1:0]   prodNeg;
    logic [WIDTH-1:0]     quotNeg, remNeg;
    logic                 resNeg, remSignNeg;
    logic                 lastIter;

    muldiv_negate #(.W(WIDTH))   uNegA   (.val_i(inRD1),              .neg_o(inNegA));
    muldiv_negate #(.W(WIDTH))   uNegB   (.val_i(inRD2),              .neg_o(inNegB));
    muldiv_negate #(.W(2*WIDTH)) uNegP   (.val_i(acc_q),              .neg_o(prodNeg));
    muldiv_negate #(.W(WIDTH))   uNegQ   (.val_i(quot_q),             .neg_o(quotNeg));
    muldiv_negate #(.W(WIDTH))   uNegR   (.val_i(rem_q[WIDTH-1:0]),   .neg_o(remNeg));

    assign inSignA = isSignedOp(op) & inRD1[WIDTH-1];
    assign inSignB = isSignedOp(op) & inRD2[WIDTH-1];
    assign inMagA  = inSignA ? inNegA : inRD1;
    assign inMagB  = inSignB ? inNegB : inRD2;

    // Multiplier sits in the low half of the accumulator and shifts out as the product shifts in.
    assign mulAddend = acc_q[0] ? aMag_q : '0;
    assign mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};

    assign divShift = {rem_q, quot_q[WIDTH-1]};
    assign divDiff  = divShift - {2'b00, bMag_q};
    assign divGe    = ~divDiff[WIDTH+1];

    assign resNeg     = isSignedOp(op_q) & (signA_q ^ signB_q);
    assign remSignNeg = isSignedOp(op_q) & signA_q;
    assign lastIter   = (cnt_q == CNT_W'(ITER - 1));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        aMag_d    = aMag_q;
        bMag_d    = bMag_q;
        origA_d   = origA_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divZero_d = divZero_q;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = op;
                    aMag_d  = inMagA;
                    bMag_d  = inMagB;
                    origA_d = inRD1;
                    signA_d = inSignA;
                    signB_d = inSignB;
                    acc_d   = {{WIDTH{1'b0}}, inMagB};
                    rem_d   = '0;
                    quot_d  = inMagA;
                    cnt_d   = '0;
                    state_d = op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                acc_d = {mulSum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (lastIter) begin
                    state_d = FIX;
                end
            end
            DIV: begin
                rem_d  = divGe ? divDiff[WIDTH:0] : divShift[WIDTH:0];
                quot_d = {quot_q[WIDTH-2:0], divGe};
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (lastIter) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = resNeg ? prodNeg : acc_q;
                end else if (bMag_q == '0) begin
                    // A zero divisor reports the untouched dividend rather than the fixed-up remainder.
                    hi_d      = origA_q;
                    lo_d      = '1;
                    divZero_d = 1'b1;
                end else begin
                    hi_d      = remSignNeg ? remNeg : rem_q[WIDTH-1:0];
                    lo_d      = resNeg ? quotNeg : quot_q;
                    divZero_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush && (state_q != IDLE)) begin
            state_d   = IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            divZero_d = divZero_q;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            aMag_q    <= '0;
            bMag_q    <= '0;
            origA_q   <= '0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            acc_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            aMag_q    <= aMag_d;
            bMag_q    <= bMag_d;
            origA_q   <= origA_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divZero_q <= divZero_d;
        end
    end

    assign outHi   = hi_q;
    assign outLo   = lo_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign divZero = divZero_q;
    assign stall   = busy & (start | readHiLo);

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EX pipeline register outputs: operand A (RD1, rs) and operand B (RD2, rt).
- Performs iterative 32-bit MULT/MULTU/DIV/DIVU into the architectural HI/LO registers, one bit per cycle.
- Raises a stall to hold the front end and the ID/EX register while a new muldiv or an mfhi/mflo hits an unfinished operation.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  execute-stage instruction is a muldiv op; sampled at posedge.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- inRD1  input  WIDTH  rs operand (multiplicand / dividend).
- inRD2  input  WIDTH  rt operand (multiplier / divisor).
- readHiLo  input  1  decode stage holds mfhi/mflo.
- flush  input  1  abort the in-flight operation.
- outHi  output  WIDTH  HI register.
- outLo  output  WIDTH  LO register.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO are updated.
- divZero  output  1  sticky: last completed divide had divisor 0.
- stall  output  1  hazard request to PC, IF/ID and ID/EX.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - outHi=0, outLo=0, busy=0, done=0, divZero=0, iteration counter=0.
  - Reset overrides start and flush in the same cycle.
  - Reset mid-operation discards the partial result.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 latches op and operands.
  - Signed ops latch |inRD1| and |inRD2| plus both sign bits. Unsigned ops latch the raw values.
  - Next state is MUL (op[1]=0) or DIV (op[1]=1). counter=0. busy=1 from the next cycle.
- MUL: shift-add on a 64-bit accumulator, one multiplier bit per cycle.
- DIV: restoring division, one quotient bit per cycle; the remainder register is WIDTH+1 bits.
- Iteration exit: after counter reaches ITER-1, go to FIX.
- FIX, one cycle:
  - Signed MULT: negate the 64-bit product if the operand signs differ.
  - Signed DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - Pulse done=1 for exactly one cycle. Return to IDLE with busy=0.
- Latency: start sampled at edge T gives HI/LO updated and done=1 after edge T+ITER+1 (T+33).
  - A back-to-back start is accepted in the cycle busy falls, i.e. in the IDLE cycle.
- Divide by zero (divisor==0): no early exit; same latency. HI = original dividend (inRD1 as latched), LO = all ones, divZero=1.
  - Any later completed divide with a nonzero divisor clears divZero. Multiplies leave it unchanged.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: falls out of the magnitude path. LO=0x80000000, HI=0. No flag.
- start while busy: ignored, not queued; operands are not relatched. stall=1.
- stall = busy & (start | readHiLo). This is combinational from registered busy.
  - stall=0 in the FIX-to-IDLE handoff cycle, so HI/LO are already updated when mfhi/mflo is released.
- flush=1 while busy: return to IDLE next edge. HI/LO and divZero are unchanged, no done pulse.
  - flush in IDLE has no effect; it also blocks a simultaneous start.
- Simultaneous flush and FIX: flush wins; HI/LO are not written.
- HI/LO change only in FIX. There is no mthi/mtlo path in this block.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - state encoding: IDLE, MUL, DIV, FIX.
  - MULDIV_ITER=32.
- One natural sub-module: muldiv_negate, a combinational two's-complement negate parameterised on width. It is used for operand magnitude (32) and result fix-up (64).
- FSM and datapath stay in ex_muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at T -> busy T+1..T+33; done=1 once; HI=0xFFFFFFFE, LO=0x00000001.
- MULT inRD1=0xFFFFFFFD (−3), inRD2=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21).
  - Also: DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> HI=0x00000064, LO=0xFFFFFFFF, divZero=1.
  - A following DIVU 9/4 -> LO=2, HI=1, divZero=0.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - Also: start and readHiLo pulsed at cycle T+5 -> stall=1 those cycles, second start ignored, result unchanged.
- Preload HI=0x11, LO=0x22 via MULTU 0x11_00000022-style setup. Start DIVU; flush at T+10 -> busy=0 at T+11, no done, HI/LO unchanged.
  - Repeat with rst=1 at T+10 -> all outputs 0 next cycle.
